// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches 16-bit words over req/ack,
// holds them for decode under stall, redirects on branches, stops on HLT.
module instruction_fetch_unit #(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_req,
  input  logic [15:0]       imem_rdata,
  input  logic              imem_ack,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [15:0]       op,
  output logic [ADDR_W-1:0] op_pc,
  output logic              op_valid,
  output logic              halted
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    ISSUED = 2'd1,
    HALT   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       op_q, op_d;
  logic [ADDR_W-1:0] op_pc_q, op_pc_d;
  logic              op_valid_q, op_valid_d;
  logic              op_is_hlt;

  // HLT opcode: top two bits set and the sub-op nibble all ones
  assign op_is_hlt = (op_q[15:14] == 2'b11) && (op_q[7:4] == 4'b1111);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      op_q       <= 16'h0000;
      op_pc_q    <= RESET_PC;
      op_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      op_q       <= op_d;
      op_pc_q    <= op_pc_d;
      op_valid_q <= op_valid_d;
    end
  end

  // Next-state logic: redirect beats ack in FETCH and beats stall in ISSUED
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    op_d       = op_q;
    op_pc_d    = op_pc_q;
    op_valid_d = op_valid_q;
    unique case (state_q)
      FETCH: begin
        if (redirect) begin
          pc_d = redirect_pc;
        end else if (imem_ack) begin
          op_d       = imem_rdata;
          op_pc_d    = pc_q;
          op_valid_d = 1'b1;
          pc_d       = pc_q + ADDR_W'(1);
          state_d    = ISSUED;
        end
      end
      ISSUED: begin
        if (redirect) begin
          pc_d       = redirect_pc;
          op_valid_d = 1'b0;
          state_d    = FETCH;
        end else if (!stall) begin
          op_valid_d = 1'b0;
          state_d    = op_is_hlt ? HALT : FETCH;
        end
      end
      HALT: begin
        op_valid_d = 1'b0;
      end
      default: begin
        op_valid_d = 1'b0;
        state_d    = FETCH;
      end
    endcase
  end

  assign imem_req  = (state_q == FETCH);
  assign imem_addr = pc_q;
  assign op        = op_q;
  assign op_pc     = op_pc_q;
  assign op_valid  = op_valid_q;
  assign halted    = (state_q == HALT);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed steps plus random traffic
// checked against a transaction-level model of the fetch stage.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] imem_addr;
  logic        imem_req;
  logic [15:0] imem_rdata = '0;
  logic        imem_ack = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic [15:0] op;
  logic [15:0] op_pc;
  logic        op_valid;
  logic        halted;

  logic [15:0] w_addr;
  logic        w_req;
  logic [15:0] w_rdata = '0;
  logic        w_ack = 1'b0;
  logic [15:0] w_op;
  logic [15:0] w_op_pc;
  logic        w_op_valid;
  logic        w_halted;

  int checks = 0;
  int passed = 0;

  // model: PC, held instruction, whether one is pending, halted flag
  logic [15:0] m_pc, m_op, m_op_pc;
  bit          m_have, m_halt;

  always #5 clk = ~clk;

  instruction_fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .op(op), .op_pc(op_pc), .op_valid(op_valid), .halted(halted)
  );

  instruction_fetch_unit #(.ADDR_W(16), .RESET_PC(16'hFFFF)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(w_addr), .imem_req(w_req),
    .imem_rdata(w_rdata), .imem_ack(w_ack),
    .stall(1'b0), .redirect(1'b0), .redirect_pc(16'h0000),
    .op(w_op), .op_pc(w_op_pc), .op_valid(w_op_valid), .halted(w_halted)
  );

  function automatic bit is_hlt(input logic [15:0] w);
    return (w[15:14] == 2'b11) && (w[7:4] == 4'hF);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_op = 16'h0000; m_op_pc = 16'h0000;
    m_have = 0; m_halt = 0;
  endtask

  // One clock of the fetch stage seen as transactions
  task automatic model_step();
    if (m_halt) begin
    end else if (!m_have) begin
      if (redirect) m_pc = redirect_pc;
      else if (imem_ack) begin
        m_op = imem_rdata; m_op_pc = m_pc; m_have = 1;
        m_pc = m_pc + 16'd1;
      end
    end else if (redirect) begin
      m_pc = redirect_pc; m_have = 0;
    end else if (!stall) begin
      m_have = 0;
      if (is_hlt(m_op)) m_halt = 1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".req"}, 32'(imem_req), 32'(!m_have && !m_halt));
    chk({tag, ".addr"}, 32'(imem_addr), 32'(m_pc));
    chk({tag, ".valid"}, 32'(op_valid), 32'(m_have));
    chk({tag, ".op"}, 32'(op), 32'(m_op));
    chk({tag, ".op_pc"}, 32'(op_pc), 32'(m_op_pc));
    chk({tag, ".halted"}, 32'(halted), 32'(m_halt));
  endtask

  task automatic cyc(input string tag, input bit ack, input logic [15:0] rd,
                     input bit st, input bit rdr, input logic [15:0] rpc);
    imem_ack = ack; imem_rdata = rd; stall = st;
    redirect = rdr; redirect_pc = rpc;
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [15:0] r;
    model_reset();
    #3;
    check_all("reset_low");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_all("reset_rel");
    chk("w_reset_addr", 32'(w_addr), 32'h0000FFFF);

    // wrap instance: fetch at FFFF, consume, next address wraps
    w_ack = 1'b1; w_rdata = 16'h0001;
    cyc("idle1", 0, 16'h0, 0, 0, 16'h0);
    w_ack = 1'b0;
    chk("w_valid", 32'(w_op_valid), 32'd1);
    chk("w_op_pc", 32'(w_op_pc), 32'h0000FFFF);
    chk("w_op", 32'(w_op), 32'h00000001);
    cyc("idle2", 0, 16'h0, 0, 0, 16'h0);
    chk("w_wrap_addr", 32'(w_addr), 32'h00000000);
    chk("w_wrap_req", 32'(w_req), 32'd1);
    chk("w_halted", 32'(w_halted), 32'd0);

    // basic fetch
    cyc("basic_ack", 1, 16'h8123, 0, 0, 16'h0);
    chk("basic_op", 32'(op), 32'h00008123);
    chk("basic_req", 32'(imem_req), 32'd0);
    cyc("basic_cons", 0, 16'h0, 0, 0, 16'h0);
    chk("basic_next", 32'(imem_addr), 32'h00000001);

    // stall hold
    cyc("st_ack", 1, 16'hC045, 0, 0, 16'h0);
    repeat (3) cyc("st_hold", 0, 16'h0, 1, 0, 16'h0);
    chk("st_op", 32'(op), 32'h0000C045);
    chk("st_valid", 32'(op_valid), 32'd1);
    cyc("st_rel", 0, 16'h0, 0, 0, 16'h0);
    chk("st_next", 32'(imem_addr), 32'h00000002);

    // redirect with simultaneous ack discards the word
    cyc("rd_fetch", 1, 16'h1234, 0, 1, 16'h0040);
    chk("rd_valid", 32'(op_valid), 32'd0);
    chk("rd_addr", 32'(imem_addr), 32'h00000040);
    cyc("rd_ack2", 1, 16'h5555, 0, 0, 16'h0);
    cyc("rd_issued", 0, 16'h0, 1, 1, 16'h0100);
    chk("rd2_valid", 32'(op_valid), 32'd0);
    chk("rd2_addr", 32'(imem_addr), 32'h00000100);

    // halt
    cyc("hlt_ack", 1, 16'hC0F0, 0, 0, 16'h0);
    cyc("hlt_cons", 0, 16'h0, 0, 0, 16'h0);
    chk("hlt_flag", 32'(halted), 32'd1);
    cyc("hlt_ign", 1, 16'h8000, 0, 1, 16'h0200);
    cyc("hlt_ign2", 1, 16'h8001, 0, 0, 16'h0);
    chk("hlt_req", 32'(imem_req), 32'd0);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("hlt_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;

    // random traffic with occasional mid-operation reset
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(63) == 0) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("rnd_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
      end
      r = 16'($urandom);
      if (is_hlt(r) && $urandom_range(3) != 0) r[15] = 1'b0;
      cyc("rnd", $urandom_range(1) == 1, r, $urandom_range(9) < 4,
          $urandom_range(9) == 0, 16'($urandom));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
